// File: rtl/uart_temp_pkg.sv
// Shared definitions for the temperature-link UART receiver: default line
// timing, ASCII constants, state encodings and the hex-digit decoder.
// Build option: define LOWER_HEX_EN to also accept 'a'-'f' as hex digits.
package uart_temp_pkg;

    localparam int CLK_FREQ_DEF  = 50_000_000;
    localparam int BAUD_RATE_DEF = 115_200;

    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] ZERO    = 8'h30;
    localparam logic [7:0] UPPER_A = 8'h41;
    localparam logic [7:0] LOWER_A = 8'h61;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BRK
    } rx_state_e;

    typedef enum logic [1:0] {
        P_COLLECT,
        P_GOT_CR,
        P_DISCARD
    } parse_state_e;

    typedef struct packed {
        logic       ok;
        logic [3:0] nib;
    } hex_t;

    // Map an ASCII character to its nibble; ok is low for non-digits.
    function automatic hex_t hex_decode(input logic [7:0] c);
        hex_t r;
        r.ok  = 1'b0;
        r.nib = 4'h0;
        if (c >= ZERO && c <= (ZERO + 8'd9)) begin
            r.ok  = 1'b1;
            r.nib = 4'(c - ZERO);
        end else if (c >= UPPER_A && c <= (UPPER_A + 8'd5)) begin
            r.ok  = 1'b1;
            r.nib = 4'(c - UPPER_A + 8'd10);
        end
`ifdef LOWER_HEX_EN
        else if (c >= LOWER_A && c <= (LOWER_A + 8'd5)) begin
            r.ok  = 1'b1;
            r.nib = 4'(c - LOWER_A + 8'd10);
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, start-bit qualification, mid-bit
// sampling, and a registered byte strobe or framing-error strobe.
// A low stop bit parks the receiver until the line returns high (break).
module uart_rx_byte
    import uart_temp_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLK_FREQ_DEF / BAUD_RATE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_byte_valid_o,
    output logic       frame_err_o
);

    localparam logic [8:0] HALF_LAST = 9'(CLKS_PER_BIT / 2 - 1);
    localparam logic [8:0] FULL_LAST = 9'(CLKS_PER_BIT - 1);

    // sync_q[1] is the synchronised line, sync_q[2] its one-cycle delay
    logic [2:0] sync_q;
    logic       rx_s;
    logic       fall;

    rx_state_e  state_q, state_d;
    logic [8:0] timer_q, timer_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;

    assign rx_s = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];

    // Two-flop synchroniser plus edge-detect delay; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], uart_rx_i};
        end
    end

    // Receiver state, bit timer, shift register and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RX_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic: half-bit qualify the start, then sample each bit centre.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 9'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                timer_d = '0;
                if (fall) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d   = RX_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            RX_DATA: begin
                if (timer_q == FULL_LAST) begin
                    timer_d   = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (timer_q == FULL_LAST) begin
                    timer_d = '0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_BRK;
                    end
                end
            end
            RX_BRK: begin
                timer_d = '0;
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign rx_byte_o       = byte_q;
    assign rx_byte_valid_o = valid_q;
    assign frame_err_o     = ferr_q;

endmodule

// File: rtl/uart_temp_rx.sv
// Temperature-link receiver top: byte receiver plus the ASCII line parser
// that turns "HHHH<CR><LF>" lines into a held value with a one-cycle strobe.
// Build option: define LOWER_HEX_EN to also accept 'a'-'f' as hex digits.
module uart_temp_rx
    import uart_temp_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEF,
    parameter int BAUD_RATE  = BAUD_RATE_DEF,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rx_i,
    output logic [7:0]              rx_byte_o,
    output logic                    rx_byte_valid_o,
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic                    value_valid_o,
    output logic                    frame_err_o,
    output logic                    parse_err_o
);

    localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int         VAL_W        = 4 * NUM_DIGITS;
    localparam logic [2:0] DIGITS       = 3'(NUM_DIGITS);

    logic [7:0] rx_byte_w;
    logic       rx_valid_w;
    logic       frame_err_w;
    hex_t       hex_w;

    parse_state_e     pstate_q, pstate_d;
    logic [VAL_W-1:0] acc_q, acc_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic             vvalid_q, vvalid_d;
    logic             perr_q, perr_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk            (clk),
        .reset          (reset),
        .uart_rx_i      (uart_rx_i),
        .rx_byte_o      (rx_byte_w),
        .rx_byte_valid_o(rx_valid_w),
        .frame_err_o    (frame_err_w)
    );

    assign hex_w = hex_decode(rx_byte_w);

    // Parser state, accumulator, digit count and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_q <= P_COLLECT;
            acc_q    <= '0;
            cnt_q    <= '0;
            value_q  <= '0;
            vvalid_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            pstate_q <= pstate_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            vvalid_q <= vvalid_d;
            perr_q   <= perr_d;
        end
    end

    // Line grammar: digits, CR, LF; first bad byte reports, rest of line ignored.
    always_comb begin
        pstate_d = pstate_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        vvalid_d = 1'b0;
        perr_d   = 1'b0;
        if (frame_err_w) begin
            // A corrupted byte poisons the line silently until the next LF
            pstate_d = P_DISCARD;
        end else if (rx_valid_w) begin
            unique case (pstate_q)
                P_COLLECT: begin
                    if (hex_w.ok) begin
                        if (cnt_q == DIGITS) begin
                            perr_d   = 1'b1;
                            pstate_d = P_DISCARD;
                        end else begin
                            acc_d = {acc_q[VAL_W-5:0], hex_w.nib};
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (rx_byte_w == CR) begin
                        if (cnt_q == DIGITS) begin
                            pstate_d = P_GOT_CR;
                        end else begin
                            perr_d   = 1'b1;
                            pstate_d = P_DISCARD;
                        end
                    end else if (rx_byte_w == LF) begin
                        // LF already marks a line start, so resync in place
                        perr_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        perr_d   = 1'b1;
                        pstate_d = P_DISCARD;
                    end
                end
                P_GOT_CR: begin
                    if (rx_byte_w == LF) begin
                        value_d  = acc_q;
                        vvalid_d = 1'b1;
                        cnt_d    = '0;
                        pstate_d = P_COLLECT;
                    end else begin
                        perr_d   = 1'b1;
                        pstate_d = P_DISCARD;
                    end
                end
                P_DISCARD: begin
                    if (rx_byte_w == LF) begin
                        cnt_d    = '0;
                        pstate_d = P_COLLECT;
                    end
                end
                default: begin
                    pstate_d = P_COLLECT;
                end
            endcase
        end
    end

    assign rx_byte_o       = rx_byte_w;
    assign rx_byte_valid_o = rx_valid_w;
    assign frame_err_o     = frame_err_w;
    assign value_o         = value_q;
    assign value_valid_o   = vvalid_q;
    assign parse_err_o     = perr_q;

endmodule

// File: tb/tb_uart_temp_rx.sv
// Testbench for uart_temp_rx: directed serial lines, a line-template model
// that predicts every strobe, and one per-cycle compare process.
// Runs at 64 clocks per bit to keep the run short; honours LOWER_HEX_EN.
`timescale 1ns/1ps
module tb_uart_temp_rx;

    localparam int BAUD    = 115_200;
    localparam int CPB     = 64;
    localparam int CLKF    = BAUD * CPB;
    // frame start edge to byte strobe: 9.5 bit times plus synchroniser delay
    localparam int LAT_MIN = (CPB * 19) / 2;
    localparam int LAT_MAX = LAT_MIN + 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx_i;
    logic [7:0]  rx_byte_o;
    logic        rx_byte_valid_o;
    logic [15:0] value_o;
    logic        value_valid_o;
    logic        frame_err_o;
    logic        parse_err_o;

    uart_temp_rx #(
        .CLK_FREQ  (CLKF),
        .BAUD_RATE (BAUD),
        .NUM_DIGITS(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .uart_rx_i      (uart_rx_i),
        .rx_byte_o      (rx_byte_o),
        .rx_byte_valid_o(rx_byte_valid_o),
        .value_o        (value_o),
        .value_valid_o  (value_valid_o),
        .frame_err_o    (frame_err_o),
        .parse_err_o    (parse_err_o)
    );

    always #10 clk = ~clk;

    typedef enum int {EV_BYTE, EV_FERR, EV_PERR, EV_VALUE} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [15:0] data;
        int          start;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  n_byte = 0, n_ferr = 0, n_perr = 0, n_val = 0;
    int  b_byte, b_ferr, b_perr, b_val;

    // line-template model state
    int          line_pos  = 0;
    bit          line_dead = 1'b0;
    logic [15:0] line_val  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int model_nib(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
`ifdef LOWER_HEX_EN
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
`endif
        return -1;
    endfunction

    // A good line is exactly four digits, CR, LF. The first byte that breaks
    // that template reports once; the rest of the line up to LF is silent.
    task automatic model_byte(input logic [7:0] b, input int st);
        int n;
        exp_q.push_back('{EV_BYTE, {8'h00, b}, st});
        if (line_dead) begin
            if (b == 8'h0A) begin
                line_dead = 1'b0;
                line_pos  = 0;
            end
            return;
        end
        n = model_nib(b);
        if (line_pos < 4 && n >= 0) begin
            line_val = {line_val[11:0], 4'(n)};
            line_pos++;
        end else if (line_pos == 4 && b == 8'h0D) begin
            line_pos++;
        end else if (line_pos == 5 && b == 8'h0A) begin
            exp_q.push_back('{EV_VALUE, line_val, st});
            line_pos = 0;
        end else begin
            exp_q.push_back('{EV_PERR, 16'h0, st});
            if (b == 8'h0A) line_pos = 0;
            else line_dead = 1'b1;
        end
    endtask

    task automatic model_frame_err(input int st);
        exp_q.push_back('{EV_FERR, 16'h0, st});
        line_dead = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx_i = 1'b0;
        if (stop_bit) model_byte(b, cyc);
        else model_frame_err(cyc);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx_i = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
        send_frame(8'h0D, 1'b1);
        send_frame(8'h0A, 1'b1);
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic snap();
        b_byte = n_byte; b_ferr = n_ferr; b_perr = n_perr; b_val = n_val;
    endtask

    task automatic chk_counts(input string tag, input int db, input int df, input int dp, input int dv);
        check({tag, "_bytes"},     n_byte - b_byte, db);
        check({tag, "_frame_err"}, n_ferr - b_ferr, df);
        check({tag, "_parse_err"}, n_perr - b_perr, dp);
        check({tag, "_values"},    n_val - b_val, dv);
    endtask

    always @(posedge clk) cyc++;

    logic        rst_at_edge = 1'b1;
    logic        prev_bvalid = 1'b0;
    logic [15:0] held        = '0;

    always @(posedge clk) rst_at_edge = reset;

    // Compare DUT strobes and the held value against the model every cycle.
    always @(negedge clk) begin
        int  nstrobe;
        int  lat;
        ev_t e;
        if (rst_at_edge) begin
            check("reset_outputs_zero",
                  {4'h0, rx_byte_o, rx_byte_valid_o, value_o, value_valid_o, frame_err_o, parse_err_o}, 32'h0);
            held        = '0;
            prev_bvalid = 1'b0;
        end else begin
            nstrobe = int'(rx_byte_valid_o) + int'(frame_err_o) + int'(parse_err_o) + int'(value_valid_o);
            if (nstrobe != 0) check("strobes_exclusive", nstrobe, 1);
            if (rx_byte_valid_o || frame_err_o) begin
                if (rx_byte_valid_o) n_byte++;
                else n_ferr++;
                if (exp_q.size() == 0) begin
                    check("unexpected_rx_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_event_kind", rx_byte_valid_o ? EV_BYTE : EV_FERR, e.kind);
                    if (rx_byte_valid_o) check("rx_byte", rx_byte_o, e.data);
                    lat = cyc - e.start;
                    checks++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        failures++;
                        $display("FAIL rx_latency: got %0d cycles, expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
                    end
                end
            end
            if (parse_err_o || value_valid_o) begin
                if (parse_err_o) n_perr++;
                else n_val++;
                check("parse_follows_byte", prev_bvalid, 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_parse_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("parse_event_kind", value_valid_o ? EV_VALUE : EV_PERR, e.kind);
                    if (value_valid_o) begin
                        check("value", value_o, e.data);
                        held = e.data;
                    end
                end
            end
            check("value_hold", value_o, held);
            prev_bvalid = rx_byte_valid_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        uart_rx_i = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_state", {value_valid_o, parse_err_o, frame_err_o, rx_byte_valid_o, value_o}, 20'h0);
        reset = 1'b0;
        repeat (4 * CPB) @(negedge clk);

        // 1: clean line
        snap();
        send_line("1A2F");
        check("t1_value", value_o, 16'h1A2F);
        chk_counts("t1", 6, 0, 0, 1);

        // 2: illegal character, then a good line
        snap();
        send_line("1G2F");
        chk_counts("t2a", 6, 0, 1, 0);
        check("t2a_value_kept", value_o, 16'h1A2F);
        snap();
        send_line("00FF");
        check("t2b_value", value_o, 16'h00FF);
        chk_counts("t2b", 6, 0, 0, 1);

        // 3: framing error with held break; the poisoned line ends at the next LF
        snap();
        send_frame(8'h31, 1'b0);
        repeat (2000) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        chk_counts("t3a", 0, 1, 0, 0);
        snap();
        send_line("FFFF");
        chk_counts("t3b", 6, 0, 0, 0);
        check("t3b_value_kept", value_o, 16'h00FF);
        snap();
        send_line("FFFF");
        check("t3c_value", value_o, 16'hFFFF);
        chk_counts("t3c", 6, 0, 0, 1);

        // 4: short low glitch on an idle line
        snap();
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        chk_counts("t4a", 0, 0, 0, 0);
        send_line("0001");
        check("t4_value", value_o, 16'h0001);

        // 5: too many and too few digits, then reset mid-byte
        snap();
        send_line("12345");
        chk_counts("t5a", 7, 0, 1, 0);
        snap();
        send_line("12");
        chk_counts("t5b", 4, 0, 1, 0);
        check("t5_value_kept", value_o, 16'h0001);
        send_frame(8'h41, 1'b1);
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check("t5_no_pending_before_reset", exp_q.size(), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_value_in_reset", value_o, 16'h0000);
        reset     = 1'b0;
        line_pos  = 0;
        line_dead = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        snap();
        send_line("ABCD");
        check("t5_value", value_o, 16'hABCD);
        chk_counts("t5c", 6, 0, 0, 1);

        // 6: lowercase digits
        snap();
        send_line("beef");
`ifdef LOWER_HEX_EN
        check("t6_value", value_o, 16'hBEEF);
        chk_counts("t6", 6, 0, 0, 1);
`else
        check("t6_value_kept", value_o, 16'hABCD);
        chk_counts("t6", 6, 0, 1, 0);
`endif

        repeat (4 * CPB) @(negedge clk);
        check("no_missing_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
